// File: rtl/pwm_deadtime_gen_if.sv
// Signal bundle between the PWM block, the register file and the complementary gate-drive stage.
interface pwm_deadtime_gen_if #(
    parameter int CHANNELS = 3,
    parameter int DT_WIDTH = 8
);
    logic                enable;
    logic [DT_WIDTH-1:0] dead_time;
    logic [CHANNELS-1:0] pwm_in;
    logic                fault_n;
    logic                fault_clear;
    logic [CHANNELS-1:0] out_hi;
    logic [CHANNELS-1:0] out_lo;
    logic                fault_latched;

    modport master (
        output enable, dead_time, pwm_in, fault_n, fault_clear,
        input  out_hi, out_lo, fault_latched
    );

    modport slave (
        input  enable, dead_time, pwm_in, fault_n, fault_clear,
        output out_hi, out_lo, fault_latched
    );
endinterface

// File: rtl/pwm_deadtime_gen.sv
// Complementary high/low gate-drive generator with per-channel dead time and a latched fault shutdown.
module pwm_deadtime_gen #(
    parameter int CHANNELS = 3,
    parameter int DT_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    pwm_deadtime_gen_if.slave bus
);

    typedef enum logic [2:0] {
        SAFE     = 3'd0,
        LO_ON    = 3'd1,
        DT_TO_HI = 3'd2,
        HI_ON    = 3'd3,
        DT_TO_LO = 3'd4
    } state_t;

    logic fault_meta_reg;
    logic fault_s_reg;
    logic fault_latched_reg;
    logic fault_latched_next;
    logic force_off;

    logic [CHANNELS-1:0] out_hi_w;
    logic [CHANNELS-1:0] out_lo_w;

    // Synchronizer flops idle at 1 so reset never looks like a fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_meta_reg    <= 1'b1;
            fault_s_reg       <= 1'b1;
            fault_latched_reg <= 1'b0;
        end else begin
            fault_meta_reg    <= bus.fault_n;
            fault_s_reg       <= fault_meta_reg;
            fault_latched_reg <= fault_latched_next;
        end
    end

    always_comb begin
        fault_latched_next = fault_latched_reg;
        if (!fault_s_reg) begin
            fault_latched_next = 1'b1;
        end else if (bus.fault_clear) begin
            fault_latched_next = 1'b0;
        end
    end

    assign force_off         = !bus.enable || fault_latched_reg || !fault_s_reg;
    assign bus.fault_latched = fault_latched_reg;
    assign bus.out_hi        = out_hi_w;
    assign bus.out_lo        = out_lo_w;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            state_t              state_reg;
            state_t              state_next;
            logic [DT_WIDTH-1:0] cnt_reg;
            logic [DT_WIDTH-1:0] cnt_next;
            logic                hi_reg;
            logic                lo_reg;
            logic                pwm;

            assign pwm = bus.pwm_in[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= SAFE;
                    cnt_reg   <= '0;
                    hi_reg    <= 1'b0;
                    lo_reg    <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    hi_reg    <= (state_next == HI_ON);
                    lo_reg    <= (state_next == LO_ON);
                end
            end

            // Transitions out of an ON state spend one cycle of the dead
            // interval in the edge itself, hence the dead_time-1 load there.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                if (force_off) begin
                    state_next = SAFE;
                    cnt_next   = '0;
                end else begin
                    case (state_reg)
                        SAFE: begin
                            state_next = pwm ? DT_TO_HI : DT_TO_LO;
                            cnt_next   = bus.dead_time;
                        end
                        LO_ON: begin
                            if (pwm) begin
                                if (bus.dead_time == '0) begin
                                    state_next = HI_ON;
                                end else begin
                                    state_next = DT_TO_HI;
                                    cnt_next   = bus.dead_time - 1'b1;
                                end
                            end
                        end
                        HI_ON: begin
                            if (!pwm) begin
                                if (bus.dead_time == '0) begin
                                    state_next = LO_ON;
                                end else begin
                                    state_next = DT_TO_LO;
                                    cnt_next   = bus.dead_time - 1'b1;
                                end
                            end
                        end
                        DT_TO_HI: begin
                            if (!pwm) begin
                                state_next = LO_ON;
                                cnt_next   = '0;
                            end else if (cnt_reg == '0) begin
                                state_next = HI_ON;
                            end else begin
                                cnt_next = cnt_reg - 1'b1;
                            end
                        end
                        DT_TO_LO: begin
                            if (pwm) begin
                                state_next = HI_ON;
                                cnt_next   = '0;
                            end else if (cnt_reg == '0) begin
                                state_next = LO_ON;
                            end else begin
                                cnt_next = cnt_reg - 1'b1;
                            end
                        end
                        default: begin
                            state_next = SAFE;
                            cnt_next   = '0;
                        end
                    endcase
                end
            end

            assign out_hi_w[gi] = hi_reg;
            assign out_lo_w[gi] = lo_reg;
        end
    endgenerate

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen: expected gate states queued with each step, compared after the edge.
module tb_pwm_deadtime_gen;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        string      tag;
        logic [2:0] hi;
        logic [2:0] lo;
        logic       fl;
    } exp_t;

    exp_t sb[$];

    pwm_deadtime_gen_if #(.CHANNELS(3), .DT_WIDTH(8)) bus ();

    pwm_deadtime_gen #(.CHANNELS(3), .DT_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare_front();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (bus.out_hi === e.hi && bus.out_lo === e.lo && bus.fault_latched === e.fl)
        else begin
            errors++;
            $error("FAIL %s: hi/lo/fl got %b/%b/%b expected %b/%b/%b",
                   e.tag, bus.out_hi, bus.out_lo, bus.fault_latched, e.hi, e.lo, e.fl);
        end
    endtask

    task automatic push_exp(input string tag, input logic [2:0] hi, input logic [2:0] lo, input logic fl);
        exp_t e;
        e.tag = tag;
        e.hi  = hi;
        e.lo  = lo;
        e.fl  = fl;
        sb.push_back(e);
    endtask

    // One clock: expectation for the state after the coming edge, then check.
    task automatic step(input string tag, input logic [2:0] hi, input logic [2:0] lo, input logic fl);
        push_exp(tag, hi, lo, fl);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    task automatic check_now(input string tag, input logic [2:0] hi, input logic [2:0] lo, input logic fl);
        push_exp(tag, hi, lo, fl);
        compare_front();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        bus.enable      = 1'b0;
        bus.dead_time   = 8'd4;
        bus.pwm_in      = 3'b000;
        bus.fault_n     = 1'b1;
        bus.fault_clear = 1'b0;

        @(posedge clk);
        #1;
        check_now("reset", 3'b000, 3'b000, 1'b0);

        // Startup: SAFE then one DT state of dead_time+1 cycles, then low sides on
        rst_n      = 1'b1;
        bus.enable = 1'b1;
        for (int i = 0; i < 5; i++) step("start_dead", 3'b000, 3'b000, 1'b0);
        step("start_lo_on", 3'b000, 3'b111, 1'b0);

        // Dead time on rising edge of channel 0
        bus.pwm_in = 3'b001;
        for (int i = 0; i < 4; i++) step("rise_dead", 3'b000, 3'b110, 1'b0);
        step("rise_hi_on", 3'b001, 3'b110, 1'b0);
        step("rise_hold", 3'b001, 3'b110, 1'b0);

        // Falling edge; dead_time change mid-interval must not matter
        bus.pwm_in = 3'b000;
        step("fall_dead", 3'b000, 3'b110, 1'b0);
        bus.dead_time = 8'd1;
        for (int i = 0; i < 3; i++) step("fall_dead_dtchg", 3'b000, 3'b110, 1'b0);
        step("fall_lo_on", 3'b000, 3'b111, 1'b0);

        // Glitch suppression on channel 1
        bus.dead_time = 8'd5;
        bus.pwm_in    = 3'b010;
        for (int i = 0; i < 3; i++) step("glitch_dead", 3'b000, 3'b101, 1'b0);
        bus.pwm_in = 3'b000;
        step("glitch_lo_back", 3'b000, 3'b111, 1'b0);
        step("glitch_lo_hold", 3'b000, 3'b111, 1'b0);

        // Zero dead time, channel 2 toggling every cycle
        bus.dead_time = 8'd0;
        for (int i = 0; i < 8; i++) begin
            bus.pwm_in = (i % 2 == 0) ? 3'b100 : 3'b000;
            if (i % 2 == 0) step("zero_dt_hi", 3'b100, 3'b011, 1'b0);
            else            step("zero_dt_lo", 3'b000, 3'b111, 1'b0);
        end

        // Fault: two synchronizer cycles, then shutdown and latch
        bus.dead_time = 8'd2;
        bus.fault_n   = 1'b0;
        step("fault_sync1", 3'b000, 3'b111, 1'b0);
        step("fault_sync2", 3'b000, 3'b111, 1'b0);
        step("fault_shut", 3'b000, 3'b000, 1'b1);
        bus.fault_clear = 1'b1;
        step("fault_clr_blocked", 3'b000, 3'b000, 1'b1);
        bus.fault_clear = 1'b0;
        step("fault_hold", 3'b000, 3'b000, 1'b1);
        bus.fault_n = 1'b1;
        for (int i = 0; i < 3; i++) step("fault_released", 3'b000, 3'b000, 1'b1);
        bus.fault_clear = 1'b1;
        step("fault_cleared", 3'b000, 3'b000, 1'b0);
        bus.fault_clear = 1'b0;
        for (int i = 0; i < 3; i++) step("fault_restart_dead", 3'b000, 3'b000, 1'b0);
        step("fault_restart_lo", 3'b000, 3'b111, 1'b0);

        // Enable drop in HI_ON, then restart
        bus.dead_time = 8'd0;
        bus.pwm_in    = 3'b001;
        step("en_hi_on", 3'b001, 3'b110, 1'b0);
        bus.enable = 1'b0;
        step("en_off", 3'b000, 3'b000, 1'b0);
        step("en_off_hold", 3'b000, 3'b000, 1'b0);
        bus.enable = 1'b1;
        step("en_restart_dead", 3'b000, 3'b000, 1'b0);
        step("en_restart_on", 3'b001, 3'b110, 1'b0);

        // Asynchronous reset between edges
        #3;
        rst_n = 1'b0;
        #1;
        check_now("rst_async", 3'b000, 3'b000, 1'b0);
        @(posedge clk);
        #1;
        check_now("rst_held", 3'b000, 3'b000, 1'b0);
        rst_n         = 1'b1;
        bus.dead_time = 8'd1;
        bus.pwm_in    = 3'b000;
        step("rst_restart_dead1", 3'b000, 3'b000, 1'b0);
        step("rst_restart_dead2", 3'b000, 3'b000, 1'b0);
        step("rst_restart_lo", 3'b000, 3'b111, 1'b0);

        // Random soak: gates of a channel never both on
        for (int i = 0; i < 400; i++) begin
            bus.pwm_in    = 3'($urandom_range(0, 7));
            bus.dead_time = 8'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            checks++;
            assert ((bus.out_hi & bus.out_lo) === 3'b000)
            else begin
                errors++;
                $error("FAIL soak_overlap: hi/lo got %b/%b expected no common bit", bus.out_hi, bus.out_lo);
            end
        end
        bus.pwm_in    = 3'b000;
        bus.dead_time = 8'd0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
        end
        step("soak_settle_lo", 3'b000, 3'b111, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
